// File: rtl/psg_bus_write_decoder_if.sv
// CPU-side write bus of the PSG register decoder: data byte, write strobe and
// the idle/ready handshake back to the CPU.
interface psg_bus_write_decoder_if;
    logic [7:0] data_in;
    logic       wr_n;
    logic       ready;

    modport master (output data_in, output wr_n, input ready);
    modport slave  (input data_in, input wr_n, output ready);
endinterface

// File: rtl/psg_bus_write_decoder.sv
// SN76489-style latch/data write decoder and PSG control register file.
// Optional PSG_DATA_WRITES_ALL_EN: data bytes also update volume/noise registers.
module psg_bus_write_decoder #(
    parameter int NUM_TONES                = 3,
    parameter int ATTENUATION_CONTROL_BITS = 4,
    parameter int FREQUENCY_COUNTER_BITS   = 10,
    parameter int NOISE_CONTROL_BITS       = 3,
    parameter int WRITE_BUSY_CYCLES        = 32
) (
    input  logic clk,
    input  logic reset,
    psg_bus_write_decoder_if.slave bus,
    output logic [(NUM_TONES+1)*ATTENUATION_CONTROL_BITS-1:0] attn_flat,
    output logic [NUM_TONES*FREQUENCY_COUNTER_BITS-1:0]       freq_flat,
    output logic [NOISE_CONTROL_BITS-1:0]                     noise_ctrl,
    output logic noise_reset,
    output logic write_overrun
);
    localparam int AB = ATTENUATION_CONTROL_BITS;
    localparam int FB = FREQUENCY_COUNTER_BITS;

    logic [AB-1:0] attn [NUM_TONES+1];
    logic [FB-1:0] freq [NUM_TONES];
    logic [NOISE_CONTROL_BITS-1:0] noise_q;
    logic [1:0] latch_ch;
    logic       latch_vol;
    logic       s1, s2, s3;
    logic       ready_q;
    logic [7:0] busy_cnt;
    logic [7:0] d;
    logic       strobe;
    logic       accept;

    assign d      = bus.data_in;
    assign strobe = !s2 && s3;
    assign accept = strobe && ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NUM_TONES; i++) attn[i] <= '1;
            for (int i = 0; i < NUM_TONES; i++) freq[i] <= '0;
            noise_q       <= '0;
            latch_ch      <= 2'd0;
            latch_vol     <= 1'b0;
            s1            <= 1'b1;
            s2            <= 1'b1;
            s3            <= 1'b1;
            ready_q       <= 1'b1;
            busy_cnt      <= 8'd0;
            noise_reset   <= 1'b0;
            write_overrun <= 1'b0;
        end else begin
            s1          <= bus.wr_n;
            s2          <= s1;
            s3          <= s2;
            noise_reset <= 1'b0;
            if (strobe && !ready_q) write_overrun <= 1'b1;
            if (accept) begin
                ready_q  <= 1'b0;
                busy_cnt <= 8'(WRITE_BUSY_CYCLES);
                if (d[7]) begin
                    latch_ch  <= d[6:5];
                    latch_vol <= d[4];
                    if (d[4]) begin
                        attn[d[6:5]] <= d[AB-1:0];
                    end else if (d[6:5] == 2'd3) begin
                        noise_q     <= d[NOISE_CONTROL_BITS-1:0];
                        noise_reset <= 1'b1;
                    end else begin
                        freq[d[6:5]][3:0] <= d[3:0];
                    end
                end else if (!latch_vol && latch_ch != 2'd3) begin
                    freq[latch_ch][FB-1:4] <= d[5:0];
`ifdef PSG_DATA_WRITES_ALL_EN
                end else if (latch_vol) begin
                    attn[latch_ch] <= d[AB-1:0];
                end else begin
                    noise_q     <= d[NOISE_CONTROL_BITS-1:0];
                    noise_reset <= 1'b1;
`endif
                end
            end else if (!ready_q) begin
                busy_cnt <= busy_cnt - 8'd1;
                if (busy_cnt == 8'd1) ready_q <= 1'b1;
            end
        end
    end

    assign bus.ready  = ready_q;
    assign noise_ctrl = noise_q;

    for (genvar i = 0; i <= NUM_TONES; i++) begin : g_attn
        assign attn_flat[i*AB +: AB] = attn[i];
    end
    for (genvar i = 0; i < NUM_TONES; i++) begin : g_freq
        assign freq_flat[i*FB +: FB] = freq[i];
    end
endmodule

// File: tb/tb_psg_bus_write_decoder.sv
// Directed vector bench for psg_bus_write_decoder: register decode,
// handshake timing, overrun and reset-mid-busy sequences.
module tb_psg_bus_write_decoder;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] attn_flat;
    logic [29:0] freq_flat;
    logic [2:0]  noise_ctrl;
    logic noise_reset, write_overrun;
    int errors = 0;
    int checks = 0;

    psg_bus_write_decoder_if bus ();

    psg_bus_write_decoder dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .attn_flat(attn_flat), .freq_flat(freq_flat),
        .noise_ctrl(noise_ctrl), .noise_reset(noise_reset),
        .write_overrun(write_overrun)
    );

    always #5 clk = ~clk;

`ifdef PSG_DATA_WRITES_ALL_EN
    localparam logic [15:0] A3  = 16'h3F5F;
    localparam logic [2:0]  N_D = 3'd2;
    localparam int          P_D = 1;
`else
    localparam logic [15:0] A3  = 16'h0F5F;
    localparam logic [2:0]  N_D = 3'd5;
    localparam int          P_D = 0;
`endif

    typedef struct {
        logic [7:0]  b;
        logic [15:0] attn;
        logic [29:0] freq;
        logic [2:0]  noise;
        int          pulses;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fall wr_n just after a negedge, hold 4 edges, follow the busy window.
    task automatic do_write(input logic [7:0] b, output int low,
                            output int pulses, output int first_low,
                            output logic [15:0] attn_e1,
                            output logic [29:0] freq_e1);
        @(negedge clk);
        bus.data_in = b;
        bus.wr_n = 1'b0;
        low = 0;
        pulses = 0;
        first_low = -1;
        attn_e1 = '0;
        freq_e1 = '0;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                attn_e1 = attn_flat;
                freq_e1 = freq_flat;
            end
            if (e == 3) bus.wr_n = 1'b1;
            if (noise_reset) pulses++;
            if (!bus.ready) begin
                if (first_low < 0) first_low = e;
                low++;
            end else if (low > 0) begin
                break;
            end
        end
        bus.wr_n = 1'b1;
    endtask

    initial begin
        int low, pulses, first_low, waited;
        logic [15:0] a1, prev_attn;
        logic [29:0] f1, prev_freq;

        v[0]  = '{8'h8E, 16'hFFFF, 30'h0000_00E, 3'd0, 0};
        v[1]  = '{8'h0F, 16'hFFFF, 30'h0000_0FE, 3'd0, 0};
        v[2]  = '{8'hDF, 16'hFFFF, 30'h0000_0FE, 3'd0, 0};
        v[3]  = '{8'hB5, 16'hFF5F, 30'h0000_0FE, 3'd0, 0};
        v[4]  = '{8'hE6, 16'hFF5F, 30'h0000_0FE, 3'd6, 1};
        v[5]  = '{8'hE6, 16'hFF5F, 30'h0000_0FE, 3'd6, 1};
        v[6]  = '{8'hF0, 16'h0F5F, 30'h0000_0FE, 3'd6, 0};
        v[7]  = '{8'h03, A3,       30'h0000_0FE, 3'd6, 0};
        v[8]  = '{8'hC3, A3,       30'h0030_00FE, 3'd6, 0};
        v[9]  = '{8'h2A, A3,       30'h2A30_00FE, 3'd6, 0};
        v[10] = '{8'hA9, A3,       30'h2A30_24FE, 3'd6, 0};
        v[11] = '{8'h3F, A3,       30'h2A3F_E4FE, 3'd6, 0};
        v[12] = '{8'hE5, A3,       30'h2A3F_E4FE, 3'd5, 1};
        v[13] = '{8'h02, A3,       30'h2A3F_E4FE, N_D,  P_D};

        reset = 1'b1;
        bus.wr_n = 1'b1;
        bus.data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_attn", 32'(attn_flat), 32'h0000_FFFF);
        chk("rst_freq", 32'(freq_flat), 32'h0);
        chk("rst_noise", 32'(noise_ctrl), 32'h0);
        chk("rst_ready", 32'(bus.ready), 32'h1);
        chk("rst_ovr", 32'(write_overrun), 32'h0);
        chk("rst_nrst", 32'(noise_reset), 32'h0);

        prev_attn = 16'hFFFF;
        prev_freq = 30'h0;
        for (int i = 0; i < 14; i++) begin
            do_write(v[i].b, low, pulses, first_low, a1, f1);
            chk($sformatf("v%0d_attn_pre", i), 32'(a1), 32'(prev_attn));
            chk($sformatf("v%0d_freq_pre", i), 32'(f1), 32'(prev_freq));
            chk($sformatf("v%0d_first_low", i), 32'(first_low), 32'd2);
            chk($sformatf("v%0d_busy_len", i), 32'(low), 32'd32);
            chk($sformatf("v%0d_attn", i), 32'(attn_flat), 32'(v[i].attn));
            chk($sformatf("v%0d_freq", i), 32'(freq_flat), 32'(v[i].freq));
            chk($sformatf("v%0d_noise", i), 32'(noise_ctrl), 32'(v[i].noise));
            chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'(v[i].pulses));
            chk($sformatf("v%0d_ovr", i), 32'(write_overrun), 32'h0);
            prev_attn = v[i].attn;
            prev_freq = v[i].freq;
        end

        // Overrun: second strobe 5 cycles after the accept edge is dropped.
        @(negedge clk);
        bus.data_in = 8'h90;
        bus.wr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.wr_n = 1'b1;
        chk("ovr_first_ready", 32'(bus.ready), 32'h0);
        chk("ovr_first_attn", 32'(attn_flat), 32'(A3 & 16'hFFF0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.data_in = 8'h9A;
        bus.wr_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_flag", 32'(write_overrun), 32'h1);
        chk("ovr_attn_kept", 32'(attn_flat), 32'(A3 & 16'hFFF0));
        waited = 0;
        while (!bus.ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("ovr_ready_back", 32'(bus.ready), 32'h1);
        repeat (6) @(posedge clk);
        #1;
        chk("ovr_held_low_once", 32'(bus.ready), 32'h1);
        chk("ovr_attn_final", 32'(attn_flat), 32'(A3 & 16'hFFF0));
        chk("ovr_sticky", 32'(write_overrun), 32'h1);
        bus.wr_n = 1'b1;
        repeat (4) @(posedge clk);

        // Reset in the middle of a busy window.
        @(negedge clk);
        bus.data_in = 8'hC5;
        bus.wr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.ready), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.ready), 32'h1);
        chk("mid_rst_attn", 32'(attn_flat), 32'h0000_FFFF);
        chk("mid_rst_freq", 32'(freq_flat), 32'h0);
        chk("mid_rst_ovr", 32'(write_overrun), 32'h0);
        chk("mid_rst_noise", 32'(noise_ctrl), 32'h0);
        bus.wr_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.ready), 32'h1);
        chk("post_rst_freq", 32'(freq_flat), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
